// File: rtl/axi_4_mst_pkg.sv
// Shared AXI4-Lite definitions for the axi_4_mst master: bus widths, response codes, handshake levels.
// Optional watchdog support in the master is enabled with AXI_MST_TIMEOUT_EN.
package axi_4_mst_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic LVL_ASSERT   = 1'b1;
   localparam logic LVL_DEASSERT = 1'b0;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/axi_4_mst_wdog.sv
// Wait-state watchdog for axi_4_mst; only built when AXI_MST_TIMEOUT_EN is defined.
// Counts enabled cycles since the last clear and flags the final cycle of the budget.
`ifdef AXI_MST_TIMEOUT_EN
module axi_4_mst_wdog
   import axi_4_mst_pkg::*;
#(
   parameter int C_LIMIT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int CNT_W = (C_LIMIT > 1) ? $clog2(C_LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = enable && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !enable) begin
         cnt_d = '0;
      end else if (!expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/axi_4_mst.sv
// AXI4-Lite master: one user command in flight, converted to a single AXI read or write beat.
// Define AXI_MST_TIMEOUT_EN to abort stalled transactions with SLVERR after C_TIMEOUT_CYCLES.
module axi_4_mst
   import axi_4_mst_pkg::*;
#(
   parameter int C_AXI_ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int C_AXI_DATA_WIDTH = AXI_DATA_WIDTH,
   parameter int C_TIMEOUT_CYCLES = 256
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic                          CMD_VALID,
   output logic                          CMD_READY,
   input  logic                          CMD_WRITE,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
   input  logic [C_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
   output logic                          RSP_VALID,
   input  logic                          RSP_READY,
   output logic                          RSP_WRITE,
   output logic [C_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
   output logic [1:0]                    RSP_RESP,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP
);

   localparam int STRB_W = strb_width(C_AXI_DATA_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WR_REQ       = 3'd1,
      ST_WR_RESP      = 3'd2,
      ST_RD_REQ       = 3'd3,
      ST_RD_DATA      = 3'd4,
      ST_RESP         = 3'd5,
      ST_TIMEOUT_RESP = 3'd6
   } state_e;

   state_e                      state_q, state_d;
   logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]           wstrb_q, wstrb_d;
   logic                        write_q, write_d;
   logic                        aw_done_q, aw_done_d;
   logic                        w_done_q, w_done_d;
   logic                        rsp_write_q, rsp_write_d;
   logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                  rsp_resp_q, rsp_resp_d;

   logic cmd_fire;
   logic aw_fire;
   logic w_fire;
   logic ar_fire;
   logic timeout_fire;

   assign cmd_fire = CMD_VALID && CMD_READY;
   assign aw_fire  = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_fire   = M_AXI_WVALID && M_AXI_WREADY;
   assign ar_fire  = M_AXI_ARVALID && M_AXI_ARREADY;

   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = wdata_q;
   assign M_AXI_WSTRB  = wstrb_q;
   assign M_AXI_AWPROT = AXI_PROT_DEFAULT;
   assign M_AXI_ARPROT = AXI_PROT_DEFAULT;
   assign RSP_WRITE    = rsp_write_q;
   assign RSP_RDATA    = rsp_rdata_q;
   assign RSP_RESP     = rsp_resp_q;

`ifdef AXI_MST_TIMEOUT_EN
   logic wdog_enable;
   logic wdog_clear;
   logic wdog_expired;

   assign wdog_enable = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                        (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
   assign wdog_clear  = (state_d != state_q);

   axi_4_mst_wdog #(
      .C_LIMIT (C_TIMEOUT_CYCLES)
   ) u_wdog (
      .clk     (M_AXI_ACLK),
      .rst_n   (M_AXI_ARESETN),
      .enable  (wdog_enable),
      .clear   (wdog_clear),
      .expired (wdog_expired)
   );
`endif

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      timeout_fire = 1'b0;
      case (state_q)
         ST_IDLE:    if (cmd_fire) state_d = CMD_WRITE ? ST_WR_REQ : ST_RD_REQ;
         ST_WR_REQ:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_WR_RESP;
         ST_WR_RESP: if (M_AXI_BVALID) state_d = ST_RESP;
         ST_RD_REQ:  if (ar_fire) state_d = ST_RD_DATA;
         ST_RD_DATA: if (M_AXI_RVALID) state_d = ST_RESP;
         ST_RESP:    if (RSP_READY) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
`ifdef AXI_MST_TIMEOUT_EN
      // A handshake landing on the last budget cycle still wins over the abort.
      if (wdog_expired && (state_d == state_q)) begin
         state_d      = ST_RESP;
         timeout_fire = 1'b1;
      end
`endif
   end

   always_comb begin
      CMD_READY     = LVL_DEASSERT;
      RSP_VALID     = LVL_DEASSERT;
      M_AXI_AWVALID = LVL_DEASSERT;
      M_AXI_WVALID  = LVL_DEASSERT;
      M_AXI_BREADY  = LVL_DEASSERT;
      M_AXI_ARVALID = LVL_DEASSERT;
      M_AXI_RREADY  = LVL_DEASSERT;
      case (state_q)
         ST_IDLE:    CMD_READY = LVL_ASSERT;
         ST_WR_REQ: begin
            M_AXI_AWVALID = !aw_done_q;
            M_AXI_WVALID  = !w_done_q;
         end
         ST_WR_RESP: M_AXI_BREADY  = LVL_ASSERT;
         ST_RD_REQ:  M_AXI_ARVALID = LVL_ASSERT;
         ST_RD_DATA: M_AXI_RREADY  = LVL_ASSERT;
         ST_RESP:    RSP_VALID     = LVL_ASSERT;
         default:    CMD_READY     = LVL_DEASSERT;
      endcase
   end

   always_comb begin
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      write_d     = write_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      if (cmd_fire) begin
         addr_d    = CMD_ADDR;
         wdata_d   = CMD_WDATA;
         wstrb_d   = CMD_WSTRB;
         write_d   = CMD_WRITE;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end
      if (state_q == ST_WR_REQ) begin
         if (aw_fire) aw_done_d = 1'b1;
         if (w_fire)  w_done_d  = 1'b1;
      end
      if ((state_q == ST_WR_RESP) && M_AXI_BVALID) begin
         rsp_write_d = 1'b1;
         rsp_rdata_d = '0;
         rsp_resp_d  = M_AXI_BRESP;
      end
      if ((state_q == ST_RD_DATA) && M_AXI_RVALID) begin
         rsp_write_d = 1'b0;
         rsp_rdata_d = M_AXI_RDATA;
         rsp_resp_d  = M_AXI_RRESP;
      end
      if (timeout_fire) begin
         rsp_write_d = write_q;
         rsp_rdata_d = '0;
         rsp_resp_d  = RESP_SLVERR;
      end
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         write_q     <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RESP_OKAY;
      end else begin
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         write_q     <= write_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

endmodule

// File: tb/tb_axi_4_mst.sv
// Directed bench for axi_4_mst with a configurable AXI4-Lite slave responder.
// The timeout scenario is compiled only when AXI_MST_TIMEOUT_EN is defined.
module tb_axi_4_mst;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   // Slave responder configuration and state
   int            aw_wait = 0, w_wait = 0, ar_wait = 0, b_delay = 0, r_delay = 0;
   bit            ar_never = 1'b0;
   logic [1:0]    b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   logic [DW-1:0] r_data_cfg = '0;
   int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   int            b_count = 0;
   bit            aw_got, w_got, b_pend, r_pend;
   logic          aw_got_n, w_got_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_4_mst #(
      .C_AXI_ADDR_WIDTH (AW),
      .C_AXI_DATA_WIDTH (DW),
      .C_TIMEOUT_CYCLES (TMO)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (aresetn),
      .CMD_VALID     (cmd_valid),
      .CMD_READY     (cmd_ready),
      .CMD_WRITE     (cmd_write),
      .CMD_ADDR      (cmd_addr),
      .CMD_WDATA     (cmd_wdata),
      .CMD_WSTRB     (cmd_wstrb),
      .RSP_VALID     (rsp_valid),
      .RSP_READY     (rsp_ready),
      .RSP_WRITE     (rsp_write),
      .RSP_RDATA     (rsp_rdata),
      .RSP_RESP      (rsp_resp),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWPROT  (awprot),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WSTRB   (wstrb),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_ARVALID (arvalid),
      .M_AXI_ARREADY (arready),
      .M_AXI_ARADDR  (araddr),
      .M_AXI_ARPROT  (arprot),
      .M_AXI_RVALID  (rvalid),
      .M_AXI_RREADY  (rready),
      .M_AXI_RDATA   (rdata),
      .M_AXI_RRESP   (rresp)
   );

   assign awready  = awvalid && (aw_cnt >= aw_wait);
   assign wready   = wvalid && (w_cnt >= w_wait);
   assign arready  = arvalid && !ar_never && (ar_cnt >= ar_wait);
   assign aw_got_n = aw_got || (awvalid && awready);
   assign w_got_n  = w_got || (wvalid && wready);

   // B is raised one cycle after the later of AW/W completes (slave writes first),
   // R is raised on the AR handshake edge plus r_delay cycles.
   always @(posedge clk) begin
      if (!aresetn) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      end else begin
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (aw_got_n && w_got_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= b_delay;
         end else begin
            aw_got <= aw_got_n; w_got <= w_got_n;
         end
         if (b_pend) begin
            if (b_cnt == 0) begin
               bvalid <= 1'b1; bresp <= b_resp_cfg; b_pend <= 1'b0;
            end else begin
               b_cnt <= b_cnt - 1;
            end
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0; b_count <= b_count + 1;
         end
         if (arvalid && arready) begin
            if (r_delay == 0) begin
               rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg;
            end else begin
               r_pend <= 1'b1; r_cnt <= r_delay - 1;
            end
         end
         if (r_pend) begin
            if (r_cnt == 0) begin
               rvalid <= 1'b1; rdata <= r_data_cfg; rresp <= r_resp_cfg; r_pend <= 1'b0;
            end else begin
               r_cnt <= r_cnt - 1;
            end
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [SW-1:0] strb);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = '1; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = '0;
   endtask

   task automatic wait_rsp(input int start, output int lat);
      lat = start;
      while (rsp_valid !== 1'b1 && lat < start + 64) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rsp_wait_bound: rsp_valid %b after %0d cycles, expected 1", rsp_valid, lat);
      end
   endtask

   task automatic accept_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_handshakes: got %b expected 000000",
                  {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
      end
      aresetn = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
      checks++;
      if ({awaddr, araddr, wdata, wstrb, rsp_write, rsp_rdata, rsp_resp, awprot, arprot} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_regs: awaddr %h wdata %h wstrb %h rsp %b/%h/%b expected all 0",
                  awaddr, wdata, wstrb, rsp_write, rsp_rdata, rsp_resp);
      end
   endtask

   task automatic test_write_basic();
      int b0;
      int lat;
      aw_wait = 0; w_wait = 0; b_delay = 0; b_resp_cfg = 2'b00;
      b0 = b_count;
      issue_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL wr_valid_rise: aw/w %b expected 11", {awvalid, wvalid});
      end
      checks++;
      if (awaddr !== 32'h4 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF || awprot !== 3'b000) begin
         errors++;
         $display("[TB] FAIL wr_payload: addr %h data %h strb %h prot %b expected 4/deadbeef/f/000",
                  awaddr, wdata, wstrb, awprot);
      end
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL wr_same_cycle_hs: aw/w/bready %b expected 001", {awvalid, wvalid, bready});
      end
      wait_rsp(2, lat);
      checks++;
      if (lat != 4) begin
         errors++;
         $display("[TB] FAIL wr_latency: got %0d cycles expected 4", lat);
      end
      checks++;
      if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 2'b00, 32'h0}) begin
         errors++;
         $display("[TB] FAIL wr_rsp: write %b resp %b rdata %h expected 1/00/0", rsp_write, rsp_resp, rsp_rdata);
      end
      accept_rsp();
      checks++;
      if (b_count - b0 != 1) begin
         errors++;
         $display("[TB] FAIL wr_b_count: got %0d expected 1", b_count - b0);
      end
   endtask

   task automatic test_write_wready_delay();
      int b0;
      int lat;
      aw_wait = 0; w_wait = 3; b_delay = 0; b_resp_cfg = 2'b00;
      b0 = b_count;
      issue_cmd(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h3);
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL wdly_valid_rise: aw/w %b expected 11", {awvalid, wvalid});
      end
      for (int c = 2; c <= 4; c++) begin
         @(negedge clk);
         checks++;
         if ({awvalid, wvalid} !== 2'b01 || wdata !== 32'hCAFE_F00D || wstrb !== 4'h3) begin
            errors++;
            $display("[TB] FAIL wdly_hold_c%0d: aw/w %b data %h strb %h expected 01/cafef00d/3",
                     c, {awvalid, wvalid}, wdata, wstrb);
         end
      end
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL wdly_w_drop: aw/w/bready %b expected 001", {awvalid, wvalid, bready});
      end
      wait_rsp(5, lat);
      checks++;
      if (lat != 7) begin
         errors++;
         $display("[TB] FAIL wdly_latency: got %0d cycles expected 7", lat);
      end
      accept_rsp();
      repeat (3) @(negedge clk);
      checks++;
      if (b_count - b0 != 1) begin
         errors++;
         $display("[TB] FAIL wdly_b_count: got %0d expected 1", b_count - b0);
      end
      w_wait = 0;
   endtask

   task automatic test_read();
      int lat;
      ar_wait = 1; r_delay = 2; r_data_cfg = 32'h1234_5678; r_resp_cfg = 2'b00;
      issue_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         checks++;
         if (arvalid !== 1'b1 || araddr !== 32'h8 || arprot !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rd_ar_hold_c%0d: arvalid %b araddr %h prot %b expected 1/8/000",
                     c, arvalid, araddr, arprot);
         end
      end
      @(negedge clk);
      checks++;
      if ({arvalid, rready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL rd_phase: arvalid/rready %b expected 01", {arvalid, rready});
      end
      wait_rsp(3, lat);
      checks++;
      if (lat != 6) begin
         errors++;
         $display("[TB] FAIL rd_latency: got %0d cycles expected 6", lat);
      end
      checks++;
      if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b0, 2'b00, 32'h1234_5678}) begin
         errors++;
         $display("[TB] FAIL rd_rsp: write %b resp %b rdata %h expected 0/00/12345678", rsp_write, rsp_resp, rsp_rdata);
      end
      accept_rsp();
      ar_wait = 0; r_delay = 0;
   endtask

   task automatic test_read_min_latency();
      int lat;
      ar_wait = 0; r_delay = 0; r_data_cfg = 32'hA5A5_0001; r_resp_cfg = 2'b11;
      issue_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0);
      @(negedge clk);
      wait_rsp(1, lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("[TB] FAIL rd_min_latency: got %0d cycles expected 3", lat);
      end
      checks++;
      if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b0, 2'b11, 32'hA5A5_0001}) begin
         errors++;
         $display("[TB] FAIL rd_decerr: write %b resp %b rdata %h expected 0/11/a5a50001", rsp_write, rsp_resp, rsp_rdata);
      end
      accept_rsp();
   endtask

   task automatic test_slverr_hold();
      int lat;
      aw_wait = 0; w_wait = 0; b_delay = 0; b_resp_cfg = 2'b10;
      issue_cmd(1'b1, 32'h0000_0014, 32'h0000_0005, 4'h1);
      @(negedge clk);
      wait_rsp(1, lat);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready} !== {1'b1, 1'b1, 2'b10, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL slverr_hold_%0d: valid %b write %b resp %b rdata %h cmd_ready %b expected 1/1/10/0/0",
                     i, rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready);
         end
         @(negedge clk);
      end
      accept_rsp();
      @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL slverr_release: cmd_ready/rsp_valid %b expected 10", {cmd_ready, rsp_valid});
      end
      b_resp_cfg = 2'b00;
   endtask

   task automatic test_reset_mid();
      bit saw_rsp;
      saw_rsp = 1'b0;
      r_delay = 20; r_data_cfg = 32'h7777_7777; r_resp_cfg = 2'b00;
      issue_cmd(1'b0, 32'h0000_0018, 32'h0, 4'h0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_in_rd_data: rready %b expected 1", rready);
      end
      aresetn = 1'b0;
      @(negedge clk);
      checks++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write, rsp_resp} !== 9'b0 ||
          {araddr, wdata, wstrb, rsp_rdata} !== '0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_outputs: hs %b araddr %h rsp %b/%h cmd_ready %b expected 0/0/0/0/1",
                  {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, araddr, rsp_resp, rsp_rdata, cmd_ready);
      end
      aresetn = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) saw_rsp = 1'b1;
      end
      checks++;
      if (saw_rsp || cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_no_rsp: saw_rsp %b cmd_ready %b expected 0/1", saw_rsp, cmd_ready);
      end
      r_delay = 0;
   endtask

`ifdef AXI_MST_TIMEOUT_EN
   task automatic test_timeout();
      int cnt;
      cnt = 0;
      ar_never = 1'b1;
      issue_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);
      @(negedge clk);
      while (arvalid === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != TMO) begin
         errors++;
         $display("[TB] FAIL tmo_arvalid_cycles: got %0d expected %0d", cnt, TMO);
      end
      checks++;
      if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 2'b10, 32'h0}) begin
         errors++;
         $display("[TB] FAIL tmo_rsp: valid %b write %b resp %b rdata %h expected 1/0/10/0",
                  rsp_valid, rsp_write, rsp_resp, rsp_rdata);
      end
      accept_rsp();
      ar_never = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_write_basic();
      test_write_wready_delay();
      test_read();
      test_read_min_latency();
      test_slverr_hold();
      test_reset_mid();
`ifdef AXI_MST_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_bound: simulation still running at %0t", $time);
      $fatal(1, "[TB] run exceeded time bound");
   end

endmodule
